// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: fixed-latency busy window, HI/LO commit, hazard stall.
// Optional MADD/MADDU/MSUB/MSUBU accumulate ops enabled by defining MULDIV_MADD_EN.
module muldiv_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        md_valid_i,
  input  logic [3:0]  md_op_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  input  logic        md_use_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy_o,
  output logic        stall_o
);

  localparam int unsigned W   = 32;
  localparam int unsigned OPW = 4;
  localparam int unsigned CW  = 4;

  localparam logic [OPW-1:0] OP_MULT  = OPW'(1);
  localparam logic [OPW-1:0] OP_MULTU = OPW'(2);
  localparam logic [OPW-1:0] OP_DIV   = OPW'(3);
  localparam logic [OPW-1:0] OP_DIVU  = OPW'(4);
  localparam logic [OPW-1:0] OP_MTHI  = OPW'(5);
  localparam logic [OPW-1:0] OP_MTLO  = OPW'(6);
`ifdef MULDIV_MADD_EN
  localparam logic [OPW-1:0] OP_MADD  = OPW'(7);
  localparam logic [OPW-1:0] OP_MADDU = OPW'(8);
  localparam logic [OPW-1:0] OP_MSUB  = OPW'(9);
  localparam logic [OPW-1:0] OP_MSUBU = OPW'(10);
`endif

  typedef enum logic [0:0] {IDLE, RUN} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [W-1:0]    rs_q, rs_d, rt_q, rt_d;
  logic [W-1:0]    hi_q, hi_d, lo_q, lo_d;

  logic [2*W-1:0]  prod_s, prod_u, res;
  logic [W-1:0]    dvs_s, dvs_u, quo_s, rem_s, quo_u, rem_u;
  logic            div_ovf, op_is_md, op_is_div;

  function automatic logic is_md_op(input logic [OPW-1:0] op);
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: is_md_op = 1'b1;
`ifdef MULDIV_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_md_op = 1'b1;
`endif
      default: is_md_op = 1'b0;
    endcase
  endfunction

  assign op_is_md  = is_md_op(md_op_i);
  assign op_is_div = (md_op_i == OP_DIV) || (md_op_i == OP_DIVU);

  // Commit value from latched operands; the safe divisor of 1 covers both
  // divide-by-zero and INT_MIN/-1 (which then yields rs/1 = INT_MIN, rem 0).
  always_comb begin
    prod_s  = {{W{rs_q[W-1]}}, rs_q} * {{W{rt_q[W-1]}}, rt_q};
    prod_u  = {{W{1'b0}}, rs_q} * {{W{1'b0}}, rt_q};
    div_ovf = (rs_q == 32'h8000_0000) && (rt_q == 32'hFFFF_FFFF);
    dvs_s   = ((rt_q == '0) || div_ovf) ? W'(1) : rt_q;
    dvs_u   = (rt_q == '0) ? W'(1) : rt_q;
    quo_s   = W'($signed(rs_q) / $signed(dvs_s));
    rem_s   = W'($signed(rs_q) % $signed(dvs_s));
    quo_u   = rs_q / dvs_u;
    rem_u   = rs_q % dvs_u;
    res     = {hi_q, lo_q};
    case (op_q)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV:   if (rt_q != '0) res = {rem_s, quo_s};
      OP_DIVU:  if (rt_q != '0) res = {rem_u, quo_u};
`ifdef MULDIV_MADD_EN
      OP_MADD:  res = {hi_q, lo_q} + prod_s;
      OP_MADDU: res = {hi_q, lo_q} + prod_u;
      OP_MSUB:  res = {hi_q, lo_q} - prod_s;
      OP_MSUBU: res = {hi_q, lo_q} - prod_u;
`endif
      default:  res = {hi_q, lo_q};
    endcase
  end

  // Next-state: accept / MTxx while idle, count down and commit while running.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (md_valid_i) begin
          if (op_is_md) begin
            state_d = RUN;
            op_d    = md_op_i;
            rs_d    = rs_data_i;
            rt_d    = rt_data_i;
            cnt_d   = op_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          end else if (md_op_i == OP_MTHI) begin
            hi_d = rs_data_i;
          end else if (md_op_i == OP_MTLO) begin
            lo_d = rs_data_i;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d      = IDLE;
          {hi_d, lo_d} = res;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign busy_o  = (state_q == RUN);
  assign stall_o = md_use_i & (busy_o | (md_valid_i & op_is_md));

endmodule
